id_stage: RTL and testbench

Instruction decode stage of the 16-bit pipelined CPU, sitting between fetch and the execute-stage ALU. Accepts one 16-bit instruction per cycle over a valid/ready handshake, decodes it, reads the register file (with write-back bypass), and registers alu_op, both operands and destination info into the ID/EX pipeline register that drives the ALU. Handles downstream stall, flush, HALT and illegal opcodes.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/id_decoder.sv | 26 ++
 rtl/id_stage.sv | 85 ++++++++
 tb/tb_id_stage.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared ALU op codes, opcodes, instruction field positions, decode FSM state and sign-extension helpers
package cpu_pkg;
   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_XOR = 4'd4;
   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_AND  = 4'h3;
   localparam logic [3:0] OP_OR   = 4'h4;
   localparam logic [3:0] OP_XOR  = 4'h5;
   localparam logic [3:0] OP_ADDI = 4'h6;
   localparam logic [3:0] OP_LI   = 4'h7;
   localparam logic [3:0] OP_HALT = 4'hF;
   localparam int OPC_LSB = 12;
   localparam int RD_LSB  = 9;
   localparam int RS1_LSB = 6;
   localparam int RS2_LSB = 3;
   typedef enum logic {S_RUN, S_HALT} state_t;
   function automatic logic [15:0] sext6(input logic [5:0] v);
      return {{10{v[5]}}, v};
   endfunction
   function automatic logic [15:0] sext9(input logic [8:0] v);
      return {{7{v[8]}}, v};
   endfunction
endpackage

// File: rtl/id_decoder.sv
// id_decoder: combinational opcode decode; in opcode, out alu_op/use_imm/imm_sel(1=imm9)/zero_a/wb_en/is_halt/is_illegal
module id_decoder
   import cpu_pkg::*;
(
   input  logic [3:0] opcode,
   output logic [3:0] alu_op,
   output logic       use_imm,
   output logic       imm_sel,
   output logic       zero_a,
   output logic       wb_en,
   output logic       is_halt,
   output logic       is_illegal
);
   always_comb begin
      alu_op     = opcode == OP_SUB ? ALU_SUB :
                   opcode == OP_AND ? ALU_AND :
                   opcode == OP_OR  ? ALU_OR  :
                   opcode == OP_XOR ? ALU_XOR : ALU_ADD;
      use_imm    = opcode == OP_ADDI || opcode == OP_LI;
      imm_sel    = opcode == OP_LI;
      zero_a     = opcode == OP_LI;
      wb_en      = opcode >= OP_ADD && opcode <= OP_LI;
      is_halt    = opcode == OP_HALT;
      is_illegal = opcode > OP_LI && opcode < OP_HALT;
   end
endmodule

// File: rtl/id_stage.sv
// id_stage: decode stage; instr valid/ready in, rf read ports with wb bypass, ID/EX register out, stall/flush/HALT/illegal handling
module id_stage
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_valid,
   input  logic [15:0] instr,
   output logic        instr_ready,
   input  logic        ex_stall,
   input  logic        flush,
   output logic [2:0]  rf_raddr_a,
   output logic [2:0]  rf_raddr_b,
   input  logic [15:0] rf_rdata_a,
   input  logic [15:0] rf_rdata_b,
   input  logic        wb_en,
   input  logic [2:0]  wb_addr,
   input  logic [15:0] wb_data,
   output logic        ex_valid,
   output logic [3:0]  ex_alu_op,
   output logic [15:0] ex_operand_a,
   output logic [15:0] ex_operand_b,
   output logic [2:0]  ex_rd,
   output logic        ex_wb_en,
   output logic        halted,
   output logic        illegal
);
   state_t      state, state_nxt;
   logic [3:0]  dec_alu_op;
   logic        dec_use_imm, dec_imm_sel, dec_zero_a, dec_wb_en, dec_halt, dec_illegal;
   logic        accept;
   logic [15:0] reg_a, reg_b, op_a, op_b;
   id_decoder u_dec (
      .opcode     (instr[OPC_LSB +: 4]),
      .alu_op     (dec_alu_op),
      .use_imm    (dec_use_imm),
      .imm_sel    (dec_imm_sel),
      .zero_a     (dec_zero_a),
      .wb_en      (dec_wb_en),
      .is_halt    (dec_halt),
      .is_illegal (dec_illegal)
   );
   assign rf_raddr_a = instr[RS1_LSB +: 3];
   assign rf_raddr_b = instr[RS2_LSB +: 3];
   assign accept     = instr_valid && instr_ready && !flush;
   always_comb begin
      reg_a = rf_raddr_a == 3'd0 ? 16'd0 : (wb_en && wb_addr == rf_raddr_a) ? wb_data : rf_rdata_a;
      reg_b = rf_raddr_b == 3'd0 ? 16'd0 : (wb_en && wb_addr == rf_raddr_b) ? wb_data : rf_rdata_b;
      op_a  = dec_zero_a ? 16'd0 : reg_a;
      op_b  = !dec_use_imm ? reg_b : dec_imm_sel ? sext9(instr[8:0]) : sext6(instr[5:0]);
   end
   always_ff @(posedge clk)
      state <= rst ? S_RUN : state_nxt;
   always_comb
      state_nxt = (accept && (dec_halt || dec_illegal)) ? S_HALT : state;
   always_comb begin
      instr_ready = state == S_RUN && !ex_stall;
      halted      = state == S_HALT;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid     <= 1'b0;
         ex_alu_op    <= ALU_ADD;
         ex_operand_a <= 16'd0;
         ex_operand_b <= 16'd0;
         ex_rd        <= 3'd0;
         ex_wb_en     <= 1'b0;
         illegal      <= 1'b0;
      end else begin
         if (flush)
            ex_valid <= 1'b0;
         else if (accept) begin
            ex_valid     <= dec_wb_en;
            ex_alu_op    <= dec_alu_op;
            ex_operand_a <= op_a;
            ex_operand_b <= op_b;
            ex_rd        <= instr[RD_LSB +: 3];
            ex_wb_en     <= dec_wb_en;
         end else if (!ex_stall)
            ex_valid <= 1'b0;
         if (accept && dec_illegal)
            illegal <= 1'b1;
      end
   end
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed plus randomized check of id_stage against an instruction-level reference model
module tb_id_stage;
   logic        clk = 1'b0;
   logic        rst, instr_valid, ex_stall, flush, wb_en;
   logic [15:0] instr, wb_data;
   logic [2:0]  wb_addr;
   logic        instr_ready, ex_valid, ex_wb_en, halted, illegal;
   logic [2:0]  rf_raddr_a, rf_raddr_b, ex_rd;
   logic [15:0] rf_rdata_a, rf_rdata_b, ex_operand_a, ex_operand_b;
   logic [3:0]  ex_alu_op;
   logic [15:0] regs [8];
   int          n_checks = 0, n_fail = 0;
   logic        m_valid, m_wben, m_halt, m_ill;
   logic [3:0]  m_op;
   logic [15:0] m_a, m_b;
   logic [2:0]  m_rd;
   always #5 clk = ~clk;
   assign rf_rdata_a = regs[rf_raddr_a];
   assign rf_rdata_b = regs[rf_raddr_b];
   id_stage dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
      .ex_stall(ex_stall), .flush(flush), .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
      .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b), .wb_en(wb_en), .wb_addr(wb_addr),
      .wb_data(wb_data), .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_operand_a(ex_operand_a),
      .ex_operand_b(ex_operand_b), .ex_rd(ex_rd), .ex_wb_en(ex_wb_en), .halted(halted), .illegal(illegal)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask
   function automatic logic [15:0] read_reg(input logic [2:0] r);
      if (r == 3'd0) return 16'd0;
      if (wb_en && wb_addr == r) return wb_data;
      return regs[r];
   endfunction
   task automatic step(input logic v, input logic [15:0] i, input logic st, input logic fl, input logic r);
      logic [3:0] op;
      logic [5:0] i6;
      logic [8:0] i9;
      instr_valid = v; instr = i; ex_stall = st; flush = fl; rst = r;
      #1;
      check("instr_ready", instr_ready, !m_halt && !st);
      check("rf_raddr_a", rf_raddr_a, i[8:6]);
      check("rf_raddr_b", rf_raddr_b, i[5:3]);
      op = i[15:12]; i6 = i[5:0]; i9 = i[8:0];
      if (r) begin
         m_valid = 0; m_op = 0; m_a = 0; m_b = 0; m_rd = 0; m_wben = 0; m_halt = 0; m_ill = 0;
      end else if (fl)
         m_valid = 0;
      else if (v && !m_halt && !st) begin
         m_valid = 0;
         if (op >= 1 && op <= 7) begin
            m_valid = 1; m_wben = 1; m_rd = i[11:9];
            m_op = (op <= 5) ? op - 4'd1 : 4'd0;
            m_a = (op == 7) ? 16'd0 : read_reg(i[8:6]);
            m_b = (op == 6) ? 16'($signed(i6)) : (op == 7) ? 16'($signed(i9)) : read_reg(i[5:3]);
         end else if (op == 4'hF)
            m_halt = 1;
         else if (op != 0) begin
            m_halt = 1; m_ill = 1;
         end
      end else if (!st)
         m_valid = 0;
      @(posedge clk);
      #1;
      check("halted", halted, m_halt);
      check("illegal", illegal, m_ill);
      check("ex_valid", ex_valid, m_valid);
      if (m_valid) begin
         check("ex_alu_op", ex_alu_op, m_op);
         check("ex_operand_a", ex_operand_a, m_a);
         check("ex_operand_b", ex_operand_b, m_b);
         check("ex_rd", ex_rd, m_rd);
         check("ex_wb_en", ex_wb_en, m_wben);
      end
   endtask
   task automatic check_reset_values();
      check("rst ex_valid", ex_valid, 0);
      check("rst ex_alu_op", ex_alu_op, 0);
      check("rst ex_operand_a", ex_operand_a, 0);
      check("rst ex_operand_b", ex_operand_b, 0);
      check("rst ex_rd", ex_rd, 0);
      check("rst ex_wb_en", ex_wb_en, 0);
      check("rst halted", halted, 0);
      check("rst illegal", illegal, 0);
   endtask
   initial begin
      logic [3:0] op;
      logic       r;
      m_valid = 0; m_op = 0; m_a = 0; m_b = 0; m_rd = 0; m_wben = 0; m_halt = 0; m_ill = 0;
      for (int k = 0; k < 8; k++) regs[k] = 16'(k * 16'h1111);
      wb_en = 0; wb_addr = 0; wb_data = 0;
      rst = 1; instr_valid = 0; instr = 0; ex_stall = 0; flush = 0;
      @(posedge clk); #1;
      step(0, 16'h0000, 0, 0, 1);
      check_reset_values();
      regs[1] = 16'd5; regs[2] = 16'd3;
      step(1, 16'h1650, 0, 0, 0);
      check("add valid", ex_valid, 1);
      check("add op", ex_alu_op, 0);
      check("add a", ex_operand_a, 16'd5);
      check("add b", ex_operand_b, 16'd3);
      check("add rd", ex_rd, 3);
      regs[1] = 16'h0010;
      step(1, 16'h627F, 0, 0, 0);
      check("addi a", ex_operand_a, 16'h0010);
      check("addi b", ex_operand_b, 16'hFFFF);
      step(1, 16'h7500, 0, 0, 0);
      check("li a", ex_operand_a, 16'h0000);
      check("li b", ex_operand_b, 16'hFF00);
      regs[1] = 16'h0000; wb_en = 1; wb_addr = 1; wb_data = 16'h1234;
      step(1, 16'h2850, 0, 0, 0);
      check("bypass a", ex_operand_a, 16'h1234);
      check("sub op", ex_alu_op, 1);
      regs[0] = 16'hBEEF; wb_addr = 0;
      step(1, 16'h2810, 0, 0, 0);
      check("r0 a", ex_operand_a, 16'h0000);
      wb_en = 0;
      step(1, 16'h3A50, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         wb_en = 1; wb_addr = 1; wb_data = 16'(k + 16'h7700);
         step(1, 16'h1650, 1, 0, 0);
         check("stall ready", instr_ready, 0);
         check("stall op", ex_alu_op, 2);
         check("stall rd", ex_rd, 5);
      end
      wb_en = 0;
      step(1, 16'h1650, 1, 1, 0);
      check("flush valid", ex_valid, 0);
      step(1, 16'hA000, 0, 0, 0);
      check("illegal flag", illegal, 1);
      check("illegal halted", halted, 1);
      check("illegal valid", ex_valid, 0);
      step(1, 16'hF000, 0, 0, 0);
      step(1, 16'h1650, 0, 1, 0);
      check("halt stays", halted, 1);
      step(0, 16'h0000, 0, 0, 1);
      check_reset_values();
      step(1, 16'h5650, 0, 0, 0);
      check("xor valid", ex_valid, 1);
      check("xor op", ex_alu_op, 4);
      step(1, 16'hF000, 0, 0, 0);
      check("halt valid", ex_valid, 0);
      check("halt halted", halted, 1);
      check("halt illegal", illegal, 0);
      step(1, 16'h1650, 1, 0, 1);
      check_reset_values();
      for (int n = 0; n < 2000; n++) begin
         for (int k = 0; k < 8; k++) regs[k] = 16'($urandom);
         wb_en = $urandom_range(0, 1) == 1;
         wb_addr = 3'($urandom);
         wb_data = 16'($urandom);
         op = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
         r = m_halt ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) == 0);
         step($urandom_range(0, 3) != 0, {op, 12'($urandom)}, $urandom_range(0, 4) == 0,
              $urandom_range(0, 9) == 0, r);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
